bft_leaf_tx: RTL and testbench
==============================

Name: bft_leaf_tx

Overview:
- Transmit end of a BFT leaf port.
- Accepts destination-tagged payload words from a PE over a valid/ready stream, buffers them in a small FIFO, and formats them into p_sz-bit network packets on dout_leaf.
- Retransmits the same packet unchanged whenever the tree asserts resend.
- One instance per leaf; it sits between the PE and the network ports (dout_leaf_N, resend_N) of the 16-leaf tree.

Parameters:
- NUM_LEAVES, 16, leaves in the tree; address width AW = clog2(NUM_LEAVES) = 4.
- PAYLOAD_SZ, 44, payload bits per packet.
- P_SZ, 49, packet width = 1 + AW + PAYLOAD_SZ.
- FIFO_DEPTH, 4, input buffer entries; power of two, minimum 2.
- LEAF_ADDR, 0, this leaf's own address; used only by the optional feature.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- in_valid  in  1  PE word valid.
- in_ready  out  1  FIFO can accept; high when FIFO not full.
- in_dest  in  AW  destination leaf.
- in_payload  in  PAYLOAD_SZ  payload.
- dout_leaf  out  P_SZ  packet to tree: [P_SZ-1]=valid, [P_SZ-2:PAYLOAD_SZ]=dest, [PAYLOAD_SZ-1:0]=payload.
- resend  in  1  tree rejected the packet driven this cycle.
- busy  out  1  FIFO non-empty or packet on wire.

Behaviour:
- Reset: dout_leaf=0, in_ready=0 while reset low, busy=0, FIFO empty, FSM=IDLE. in_ready rises the first cycle after release.
- FIFO write: on in_valid && in_ready; stores {dest,payload}.
- Output register: dout_leaf is registered. Latency from an accepted input word to dout_leaf valid = 2 cycles when the FIFO is empty (write, then load). No bypass.
- resend is sampled in the same cycle as the packet it refers to. resend while dout_leaf valid=0 is ignored.
- FSM, IDLE: dout_leaf valid=0. If FIFO non-empty, pop and load the head into dout_leaf -> SEND.
- FSM, SEND:
  - resend=1: hold dout_leaf bit-identical -> HOLD.
  - resend=0 and FIFO non-empty: pop and load the next packet; stay in SEND. This is back-to-back, one packet per cycle.
  - resend=0 and FIFO empty: dout_leaf <= 0 -> IDLE.
- FSM, HOLD: identical to SEND but counts as a retransmit. resend=1 keeps HOLD indefinitely; there is no drop and no timeout.
- Ordering: packets leave strictly in FIFO order. A held packet is never overtaken.
- Full FIFO: in_ready=0; PE words are not accepted.
- Simultaneous push and pop when full: not permitted. in_ready depends only on the registered count, so there is no combinational ready-from-resend path.
- Empty FIFO in SEND: go to IDLE as above. No bubble is inserted while data is available.
- Pointers wrap modulo FIFO_DEPTH. The count is AW_F+1 bits, where AW_F = clog2(FIFO_DEPTH).
- Reset asserted mid-hold: the packet is discarded and dout_leaf clears asynchronously; the tree tolerates this.
- busy = (count != 0) || dout_leaf[P_SZ-1].

Optional Feature:
- Macro: BFT_LEAF_TX_STATS_EN.
- With the macro defined, add three outputs:
  - pkt_sent_cnt  32b: increments on each cycle with valid && !resend.
  - resend_cnt  32b: increments on each cycle with valid && resend.
  - self_addr_err  1b: sticky; set when a word with in_dest==LEAF_ADDR is accepted. That word is still transmitted.
  - The counters saturate at all-ones, and all three clear on reset.
- Without the macro: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package bft_pkg holds:
  - constants NUM_LEAVES, PAYLOAD_SZ, P_SZ, AW;
  - the packet field offsets (VALID_BIT, DEST_MSB/LSB);
  - the FSM state typedef {IDLE, SEND, HOLD}.
- One sub-module: bft_leaf_fifo. It is a synchronous FIFO, width AW+PAYLOAD_SZ, async active-low reset, with push/pop/full/empty/count.

Test Plan:
- Reset then a single word: dest=5, payload=44'h123 accepted at cycle 0. dout_leaf = {1'b1, 4'h5, 44'h123} at cycle 2 and 0 at cycle 3; busy falls at cycle 3.
- Burst of 4 words (dest 1..4) with no resend: four consecutive valid cycles in order, then an idle cycle. in_ready stays high throughout.
- Resend held 3 cycles on packet dest=7: dout_leaf identical for 4 cycles. The next packet appears the cycle after resend drops, and order is preserved.
- Fill the FIFO while resend is held: after 4 pushes in_ready=0 and a 5th word is not accepted. Releasing resend drains the FIFO in order and in_ready returns.
- Reset asserted while in HOLD: dout_leaf=0 immediately and busy=0. After release the FIFO is empty and the FSM is in IDLE.
- With BFT_LEAF_TX_STATS_EN and LEAF_ADDR=3: send 2 packets, one resent twice and one with dest=3. Expect pkt_sent_cnt=2, resend_cnt=2, self_addr_err=1.

Source files
------------

// File: rtl/bft_pkg.sv
// Shared constants, packet layout and FSM state type for the BFT leaf ports.
// Packet layout, MSB first: valid | dest | payload.
package bft_pkg;

    localparam int NUM_LEAVES = 16;
    localparam int AW         = $clog2(NUM_LEAVES);
    localparam int PAYLOAD_SZ = 44;
    localparam int P_SZ       = 1 + AW + PAYLOAD_SZ;
    localparam int ENTRY_W    = AW + PAYLOAD_SZ;

    localparam int VALID_BIT  = P_SZ - 1;
    localparam int DEST_MSB   = P_SZ - 2;
    localparam int DEST_LSB   = PAYLOAD_SZ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } tx_state_e;

    // Turns a buffered {dest, payload} entry into a valid wire packet.
    function automatic logic [P_SZ-1:0] make_pkt(input logic [ENTRY_W-1:0] entry);
        logic [P_SZ-1:0] pkt;
        pkt                      = '0;
        pkt[VALID_BIT]           = 1'b1;
        pkt[DEST_MSB:DEST_LSB]   = entry[ENTRY_W-1:PAYLOAD_SZ];
        pkt[PAYLOAD_SZ-1:0]      = entry[PAYLOAD_SZ-1:0];
        return pkt;
    endfunction

endpackage

// File: rtl/bft_leaf_fifo.sv
// Small synchronous FIFO buffering PE words ahead of the leaf transmitter.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module bft_leaf_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; the count guards every read, so clearing it would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bft_leaf_tx.sv
// Transmit end of a BFT leaf port: PE stream -> FIFO -> registered packet with resend hold.
// Optional statistics outputs are enabled by defining BFT_LEAF_TX_STATS_EN.
module bft_leaf_tx
    import bft_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef BFT_LEAF_TX_STATS_EN
    ,
    parameter int LEAF_ADDR  = 0
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_dest,
    input  logic [PAYLOAD_SZ-1:0] in_payload,
    output logic [P_SZ-1:0]       dout_leaf,
    input  logic                  resend,
    output logic                  busy
`ifdef BFT_LEAF_TX_STATS_EN
    ,
    output logic [31:0]           pkt_sent_cnt,
    output logic [31:0]           resend_cnt,
    output logic                  self_addr_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e          state;
    tx_state_e          next_state;
    logic [P_SZ-1:0]    dout_next;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               ready_en;

    // ready_en keeps in_ready low during reset and lets it rise one cycle after release.
    assign in_ready = ready_en && !fifo_full;
    assign push     = in_valid && in_ready;
    assign busy     = (fifo_count != '0) || dout_leaf[VALID_BIT];

    bft_leaf_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .wr_data ({in_dest, in_payload}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dout_leaf <= '0;
            ready_en  <= 1'b0;
        end else begin
            state     <= next_state;
            dout_leaf <= dout_next;
            ready_en  <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        dout_next  = dout_leaf;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                dout_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    dout_next  = make_pkt(head);
                    next_state = SEND;
                end
            end
            SEND, HOLD: begin
                if (resend) begin
                    next_state = HOLD;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    dout_next  = make_pkt(head);
                    next_state = SEND;
                end else begin
                    dout_next  = '0;
                    next_state = IDLE;
                end
            end
            default: begin
                dout_next  = '0;
                next_state = IDLE;
            end
        endcase
    end

`ifdef BFT_LEAF_TX_STATS_EN
    localparam logic [AW-1:0] SELF_ADDR = AW'(LEAF_ADDR);

    // Counters saturate rather than wrap so long runs never report a small bogus value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_sent_cnt  <= '0;
            resend_cnt    <= '0;
            self_addr_err <= 1'b0;
        end else begin
            if (dout_leaf[VALID_BIT] && !resend && (pkt_sent_cnt != '1)) begin
                pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
            end
            if (dout_leaf[VALID_BIT] && resend && (resend_cnt != '1)) begin
                resend_cnt <= resend_cnt + 32'd1;
            end
            if (push && (in_dest == SELF_ADDR)) begin
                self_addr_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bft_leaf_tx.sv
// Directed self-checking bench for bft_leaf_tx (FIFO_DEPTH=4).
// Defining BFT_LEAF_TX_STATS_EN also exercises the statistics outputs with LEAF_ADDR=3.
module tb_bft_leaf_tx;

    localparam int P_SZ = 49;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_dest;
    logic [43:0]   in_payload;
    logic [48:0]   dout_leaf;
    logic          resend;
    logic          busy;
`ifdef BFT_LEAF_TX_STATS_EN
    logic [31:0]   pkt_sent_cnt;
    logic [31:0]   resend_cnt;
    logic          self_addr_err;
`endif

    int checks = 0;
    int errors = 0;

    bft_leaf_tx #(
        .FIFO_DEPTH (4)
`ifdef BFT_LEAF_TX_STATS_EN
        ,
        .LEAF_ADDR  (3)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .in_payload (in_payload),
        .dout_leaf  (dout_leaf),
        .resend     (resend),
        .busy       (busy)
`ifdef BFT_LEAF_TX_STATS_EN
        ,
        .pkt_sent_cnt  (pkt_sent_cnt),
        .resend_cnt    (resend_cnt),
        .self_addr_err (self_addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [48:0] pkt(input logic [3:0] dest, input logic [43:0] payload);
        return {1'b1, dest, payload};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        resend     = 1'b0;
        in_dest    = '0;
        in_payload = '0;
        reset      = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        in_valid   = 1'b0;
        resend     = 1'b0;
        in_dest    = '0;
        in_payload = '0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        #1;
        checks++;
        if (dout_leaf !== '0) begin
            errors++; $display("FAIL reset_dout: got %h expected 0", dout_leaf);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_clocked: got %b expected 0", in_ready);
        end
        reset = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_release: got %b expected 1", in_ready);
        end
        checks++;
        if (dout_leaf !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got dout %h busy %b expected 0/0", dout_leaf, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_dest = 4'h5; in_payload = 44'h123;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        resend   = 1'b1;   // ignored: nothing valid on the wire
        checks++;
        if (dout_leaf !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_c1: got dout %h busy %b expected 0/1", dout_leaf, busy);
        end
        step();
        resend = 1'b0;
        checks++;
        if (dout_leaf !== pkt(4'h5, 44'h123)) begin
            errors++; $display("FAIL single_c2: got %h expected %h", dout_leaf, pkt(4'h5, 44'h123));
        end
        step();
        checks++;
        if (dout_leaf !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_c3: got dout %h busy %b expected 0/0", dout_leaf, busy);
        end
    endtask

    task automatic test_burst();
        logic [48:0] exp;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; in_dest = 4'(c + 1); in_payload = 44'(32'hA0 + c);
            end else begin
                in_valid = 1'b0;
            end
            exp = (c >= 2 && c <= 5) ? pkt(4'(c - 1), 44'(32'hA0 + c - 2)) : '0;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL burst_ready c%0d: got %b expected 1", c, in_ready);
            end
            checks++;
            if (dout_leaf !== exp) begin
                errors++; $display("FAIL burst_dout c%0d: got %h expected %h", c, dout_leaf, exp);
            end
            step();
        end
    endtask

    task automatic test_back_to_back_resend();
        logic [48:0] exp;
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            in_valid = 1'b0;
            if (c == 0) begin
                in_valid = 1'b1; in_dest = 4'h7; in_payload = 44'h7777;
            end else if (c == 1) begin
                in_valid = 1'b1; in_dest = 4'h8; in_payload = 44'h8888;
            end
            resend = (c >= 2 && c <= 4);
            if (c >= 2 && c <= 5)      exp = pkt(4'h7, 44'h7777);
            else if (c == 6)           exp = pkt(4'h8, 44'h8888);
            else                       exp = '0;
            checks++;
            if (dout_leaf !== exp) begin
                errors++; $display("FAIL resend_dout c%0d: got %h expected %h", c, dout_leaf, exp);
            end
            step();
        end
        resend = 1'b0;
    endtask

    task automatic test_fill_full();
        logic [48:0] exp;
        logic        exp_ready;
        int          idx;
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            idx      = (c <= 4) ? c : 5;
            in_valid = (c <= 6);
            in_dest  = 4'(idx + 1);
            in_payload = 44'(32'hF00 + idx);
            resend   = (c >= 2 && c <= 5);
            exp_ready = !(c == 5 || c == 6);
            if (c >= 2 && c <= 6)       exp = pkt(4'h1, 44'hF00);
            else if (c >= 7 && c <= 10) exp = pkt(4'(c - 5), 44'(32'hF00 + c - 6));
            else                        exp = '0;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL fill_ready c%0d: got %b expected %b", c, in_ready, exp_ready);
            end
            checks++;
            if (dout_leaf !== exp) begin
                errors++; $display("FAIL fill_dout c%0d: got %h expected %h", c, dout_leaf, exp);
            end
            if (c == 11) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL fill_busy_end: got %b expected 0", busy);
                end
            end
            step();
        end
        in_valid = 1'b0;
        resend   = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            in_valid   = (c <= 2);
            in_dest    = 4'(9 + c);
            in_payload = 44'(32'h999 + 32'h111 * c);
            resend     = (c >= 2);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (dout_leaf !== pkt(4'h9, 44'h999)) begin
            errors++; $display("FAIL hold_before_reset: got %h expected %h", dout_leaf, pkt(4'h9, 44'h999));
        end
        #2 reset = 1'b0;
        resend = 1'b0;
        #1;
        checks++;
        if (dout_leaf !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_async_reset: got dout %h busy %b ready %b expected 0/0/0",
                               dout_leaf, busy, in_ready);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (dout_leaf !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_after_release: got dout %h busy %b ready %b expected 0/0/1",
                               dout_leaf, busy, in_ready);
        end
        in_valid = 1'b1; in_dest = 4'hC; in_payload = 44'hCCC;
        step();
        in_valid = 1'b0;
        checks++;
        if (dout_leaf !== '0) begin
            errors++; $display("FAIL hold_relaunch_c1: got %h expected 0", dout_leaf);
        end
        step();
        checks++;
        if (dout_leaf !== pkt(4'hC, 44'hCCC)) begin
            errors++; $display("FAIL hold_relaunch_c2: got %h expected %h", dout_leaf, pkt(4'hC, 44'hCCC));
        end
        step();
    endtask

`ifdef BFT_LEAF_TX_STATS_EN
    task automatic test_stats();
        logic [48:0] exp;
        do_reset();
        checks++;
        if (pkt_sent_cnt !== 32'd0 || resend_cnt !== 32'd0 || self_addr_err !== 1'b0) begin
            errors++; $display("FAIL stats_reset: got %0d/%0d/%b expected 0/0/0",
                               pkt_sent_cnt, resend_cnt, self_addr_err);
        end
        for (int c = 0; c <= 8; c++) begin
            in_valid = 1'b0;
            if (c == 0) begin
                in_valid = 1'b1; in_dest = 4'h6; in_payload = 44'h666;
            end else if (c == 1) begin
                in_valid = 1'b1; in_dest = 4'h3; in_payload = 44'h333;
                checks++;
                if (self_addr_err !== 1'b0) begin
                    errors++; $display("FAIL stats_err_early: got %b expected 0", self_addr_err);
                end
            end
            resend = (c == 2 || c == 3 || c == 6 || c == 7);
            if (c >= 2 && c <= 4) exp = pkt(4'h6, 44'h666);
            else if (c == 5)      exp = pkt(4'h3, 44'h333);
            else                  exp = '0;
            checks++;
            if (dout_leaf !== exp) begin
                errors++; $display("FAIL stats_dout c%0d: got %h expected %h", c, dout_leaf, exp);
            end
            step();
        end
        resend = 1'b0;
        checks++;
        if (pkt_sent_cnt !== 32'd2) begin
            errors++; $display("FAIL stats_sent: got %0d expected 2", pkt_sent_cnt);
        end
        checks++;
        if (resend_cnt !== 32'd2) begin
            errors++; $display("FAIL stats_resend: got %0d expected 2", resend_cnt);
        end
        checks++;
        if (self_addr_err !== 1'b1) begin
            errors++; $display("FAIL stats_self_addr: got %b expected 1", self_addr_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back_resend();
        test_fill_full();
        test_reset_in_hold();
`ifdef BFT_LEAF_TX_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
